// File: rtl/dmem_lsu_if.sv
// rtl/dmem_lsu_if.sv - request/response and word-bus signals of the data-memory load/store unit
interface dmem_lsu_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              DMWr;
  logic [2:0]        DMCtrl;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              rsp_valid;
  logic [31:0]       rdata;
  logic              err;
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [3:0]        bus_be;
  logic [31:0]       bus_wdata;
  logic              bus_ack;
  logic [31:0]       bus_rdata;

  // master: requester and memory side; slave: the load/store unit itself
  modport master (
    output req_valid, DMWr, DMCtrl, addr, wdata, bus_ack, bus_rdata,
    input  req_ready, rsp_valid, rdata, err, bus_req, bus_we, bus_addr, bus_be, bus_wdata
  );
  modport slave (
    input  req_valid, DMWr, DMCtrl, addr, wdata, bus_ack, bus_rdata,
    output req_ready, rsp_valid, rdata, err, bus_req, bus_we, bus_addr, bus_be, bus_wdata
  );
endinterface

// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - load/store unit: one request -> word bus beat(s) -> extended load data pulse
// Optional DMEM_LSU_MISALIGN_SPLIT_EN: misaligned accesses allowed, word-crossing ones use two beats.
module dmem_lsu #(
  parameter int          ADDR_W    = 32,
  parameter logic [31:0] RST_RDATA = 32'h0000_0000
) (
  input logic      clk,
  input logic      rst,
  dmem_lsu_if.slave lsu
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BEAT1 = 2'd1;
  localparam logic [1:0] BEAT2 = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]        state;
  logic              r_we;
  logic [2:0]        r_ctrl;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_err;
  logic [31:0]       cap_lo;
  logic [31:0]       rdata_q;

  logic              illegal_ctrl;
  logic              req_bad;
  logic              split;
  logic [1:0]        off;
  logic [3:0]        size_mask;
  logic [7:0]        be8;
  logic [63:0]       wd64;
  logic [ADDR_W-1:0] word_addr;
  logic              in_beat;

  assign illegal_ctrl = lsu.DMWr ? (lsu.DMCtrl[2] || (lsu.DMCtrl[1:0] == 2'b11))
                                 : ((lsu.DMCtrl[1:0] == 2'b11) || (lsu.DMCtrl[2:1] == 2'b11));

`ifdef DMEM_LSU_MISALIGN_SPLIT_EN
  assign req_bad = illegal_ctrl;
  assign split   = |be8[7:4];
`else
  assign req_bad = illegal_ctrl
                || ((lsu.DMCtrl[1:0] == 2'b01) && lsu.addr[0])
                || ((lsu.DMCtrl[1:0] == 2'b10) && (lsu.addr[1:0] != 2'b00));
  assign split   = 1'b0;
`endif

  assign off       = r_addr[1:0];
  assign size_mask = (r_ctrl[1:0] == 2'b00) ? 4'b0001 :
                     (r_ctrl[1:0] == 2'b01) ? 4'b0011 : 4'b1111;
  assign be8       = {4'b0000, size_mask} << off;
  assign wd64      = {32'h0, r_wdata} << {off, 3'b000};
  assign word_addr = {r_addr[ADDR_W-1:2], 2'b00};
  assign in_beat   = (state == BEAT1) || (state == BEAT2);

  // d holds {upper word, lower word}; single-beat loads pass zero as the upper word
  function automatic logic [31:0] extend(input logic [63:0] d, input logic [1:0] o,
                                         input logic [2:0] ctrl);
    logic [31:0] sh;
    sh = 32'(d >> {o, 3'b000});
    case (ctrl)
      3'b000:  extend = {{24{sh[7]}}, sh[7:0]};
      3'b001:  extend = {{16{sh[15]}}, sh[15:0]};
      3'b100:  extend = {24'h0, sh[7:0]};
      3'b101:  extend = {16'h0, sh[15:0]};
      default: extend = sh;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      r_we    <= 1'b0;
      r_ctrl  <= 3'b000;
      r_addr  <= '0;
      r_wdata <= 32'h0;
      r_err   <= 1'b0;
      cap_lo  <= 32'h0;
      rdata_q <= RST_RDATA;
    end else begin
      case (state)
        IDLE: begin
          if (lsu.req_valid) begin
            r_we    <= lsu.DMWr;
            r_ctrl  <= lsu.DMCtrl;
            r_addr  <= lsu.addr;
            r_wdata <= lsu.wdata;
            r_err   <= req_bad;
            if (req_bad) begin
              rdata_q <= RST_RDATA;
              state   <= RESP;
            end else begin
              state   <= BEAT1;
            end
          end
        end
        BEAT1: begin
          if (lsu.bus_ack) begin
            if (split) begin
              cap_lo <= lsu.bus_rdata;
              state  <= BEAT2;
            end else begin
              rdata_q <= r_we ? 32'h0 : extend({32'h0, lsu.bus_rdata}, off, r_ctrl);
              state   <= RESP;
            end
          end
        end
        BEAT2: begin
          if (lsu.bus_ack) begin
            rdata_q <= r_we ? 32'h0 : extend({lsu.bus_rdata, cap_lo}, off, r_ctrl);
            state   <= RESP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // bus outputs are decoded from state so an async reset drops bus_req without a clock edge
  assign lsu.req_ready = (state == IDLE);
  assign lsu.rsp_valid = (state == RESP);
  assign lsu.err       = (state == RESP) && r_err;
  assign lsu.rdata     = rdata_q;
  assign lsu.bus_req   = in_beat;
  assign lsu.bus_we    = in_beat && r_we;
  assign lsu.bus_addr  = (state == BEAT1) ? word_addr :
                         (state == BEAT2) ? word_addr + ADDR_W'(4) : '0;
  assign lsu.bus_be    = (state == BEAT1) ? be8[3:0] :
                         (state == BEAT2) ? be8[7:4] : 4'b0000;
  assign lsu.bus_wdata = (state == BEAT1) ? wd64[31:0] :
                         (state == BEAT2) ? wd64[63:32] : 32'h0;
endmodule

// File: tb/tb_dmem_lsu.sv
// tb/tb_dmem_lsu.sv - directed self-checking bench for dmem_lsu
module tb_dmem_lsu;
  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  dmem_lsu_if #(.ADDR_W(32)) lsu_bus ();

  dmem_lsu #(.ADDR_W(32), .RST_RDATA(32'h0000_0000)) u_dut (
    .clk (clk),
    .rst (rst),
    .lsu (lsu_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // called at a negedge; returns at the negedge after the accepting edge
  task automatic issue(input logic we, input logic [2:0] ctrl, input logic [31:0] a,
                       input logic [31:0] wd);
    lsu_bus.req_valid = 1'b1;
    lsu_bus.DMWr      = we;
    lsu_bus.DMCtrl    = ctrl;
    lsu_bus.addr      = a;
    lsu_bus.wdata     = wd;
    @(posedge clk);
    @(negedge clk);
    lsu_bus.req_valid = 1'b0;
  endtask

  task automatic ack(input logic [31:0] d);
    lsu_bus.bus_ack   = 1'b1;
    lsu_bus.bus_rdata = d;
    @(posedge clk);
    @(negedge clk);
    lsu_bus.bus_ack   = 1'b0;
    lsu_bus.bus_rdata = 32'h0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk);
    vectors++; if (lsu_bus.req_ready !== 1'b1) begin miscompares++; $display("FAIL rst_req_ready got %b exp 1", lsu_bus.req_ready); end
    vectors++; if (lsu_bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_rsp_valid got %b exp 0", lsu_bus.rsp_valid); end
    vectors++; if (lsu_bus.err !== 1'b0) begin miscompares++; $display("FAIL rst_err got %b exp 0", lsu_bus.err); end
    vectors++; if (lsu_bus.bus_req !== 1'b0) begin miscompares++; $display("FAIL rst_bus_req got %b exp 0", lsu_bus.bus_req); end
    vectors++; if (lsu_bus.bus_be !== 4'b0000) begin miscompares++; $display("FAIL rst_bus_be got %b exp 0000", lsu_bus.bus_be); end
    vectors++; if (lsu_bus.bus_addr !== 32'h0) begin miscompares++; $display("FAIL rst_bus_addr got %h exp 0", lsu_bus.bus_addr); end
    vectors++; if (lsu_bus.bus_wdata !== 32'h0) begin miscompares++; $display("FAIL rst_bus_wdata got %h exp 0", lsu_bus.bus_wdata); end
    vectors++; if (lsu_bus.rdata !== 32'h0) begin miscompares++; $display("FAIL rst_rdata got %h exp 0", lsu_bus.rdata); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load_word;
    issue(1'b0, 3'b010, 32'h100, 32'h0);
    vectors++; if (lsu_bus.bus_req !== 1'b1) begin miscompares++; $display("FAIL lw_bus_req got %b exp 1", lsu_bus.bus_req); end
    vectors++; if (lsu_bus.bus_addr !== 32'h100) begin miscompares++; $display("FAIL lw_bus_addr got %h exp 00000100", lsu_bus.bus_addr); end
    vectors++; if (lsu_bus.bus_be !== 4'b1111) begin miscompares++; $display("FAIL lw_bus_be got %b exp 1111", lsu_bus.bus_be); end
    vectors++; if (lsu_bus.bus_we !== 1'b0) begin miscompares++; $display("FAIL lw_bus_we got %b exp 0", lsu_bus.bus_we); end
    vectors++; if (lsu_bus.req_ready !== 1'b0) begin miscompares++; $display("FAIL lw_req_ready got %b exp 0", lsu_bus.req_ready); end
    // a second request while busy must be ignored
    lsu_bus.req_valid = 1'b1;
    lsu_bus.addr      = 32'h500;
    @(negedge clk);
    lsu_bus.req_valid = 1'b0;
    @(negedge clk);
    vectors++; if (lsu_bus.bus_req !== 1'b1 || lsu_bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL lw_hold got req=%b rsp=%b exp req=1 rsp=0", lsu_bus.bus_req, lsu_bus.rsp_valid); end
    vectors++; if (lsu_bus.bus_addr !== 32'h100) begin miscompares++; $display("FAIL lw_addr_stable got %h exp 00000100", lsu_bus.bus_addr); end
    ack(32'hDEAD_BEEF);
    vectors++; if (lsu_bus.rsp_valid !== 1'b1) begin miscompares++; $display("FAIL lw_rsp_valid got %b exp 1", lsu_bus.rsp_valid); end
    vectors++; if (lsu_bus.rdata !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL lw_rdata got %h exp deadbeef", lsu_bus.rdata); end
    vectors++; if (lsu_bus.err !== 1'b0) begin miscompares++; $display("FAIL lw_err got %b exp 0", lsu_bus.err); end
    vectors++; if (lsu_bus.bus_req !== 1'b0) begin miscompares++; $display("FAIL lw_bus_req_after got %b exp 0", lsu_bus.bus_req); end
    @(negedge clk);
    vectors++; if (lsu_bus.rsp_valid !== 1'b0 || lsu_bus.req_ready !== 1'b1) begin miscompares++; $display("FAIL lw_pulse got rsp=%b rdy=%b exp rsp=0 rdy=1", lsu_bus.rsp_valid, lsu_bus.req_ready); end
  endtask

  task automatic test_load_byte;
    issue(1'b0, 3'b000, 32'h103, 32'h0);
    vectors++; if (lsu_bus.bus_be !== 4'b1000) begin miscompares++; $display("FAIL lb_bus_be got %b exp 1000", lsu_bus.bus_be); end
    vectors++; if (lsu_bus.bus_addr !== 32'h100) begin miscompares++; $display("FAIL lb_bus_addr got %h exp 00000100", lsu_bus.bus_addr); end
    ack(32'h8012_3456);
    vectors++; if (lsu_bus.rdata !== 32'hFFFF_FF80 || lsu_bus.rsp_valid !== 1'b1) begin miscompares++; $display("FAIL lb_rdata got %h rsp=%b exp ffffff80 rsp=1", lsu_bus.rdata, lsu_bus.rsp_valid); end
    @(negedge clk);
    issue(1'b0, 3'b100, 32'h103, 32'h0);
    vectors++; if (lsu_bus.bus_be !== 4'b1000) begin miscompares++; $display("FAIL lbu_bus_be got %b exp 1000", lsu_bus.bus_be); end
    ack(32'h8012_3456);
    vectors++; if (lsu_bus.rdata !== 32'h0000_0080 || lsu_bus.rsp_valid !== 1'b1) begin miscompares++; $display("FAIL lbu_rdata got %h rsp=%b exp 00000080 rsp=1", lsu_bus.rdata, lsu_bus.rsp_valid); end
    @(negedge clk);
    issue(1'b0, 3'b001, 32'h102, 32'h0);
    vectors++; if (lsu_bus.bus_be !== 4'b1100) begin miscompares++; $display("FAIL lh_bus_be got %b exp 1100", lsu_bus.bus_be); end
    ack(32'h9ABC_1234);
    vectors++; if (lsu_bus.rdata !== 32'hFFFF_9ABC) begin miscompares++; $display("FAIL lh_rdata got %h exp ffff9abc", lsu_bus.rdata); end
    @(negedge clk);
  endtask

  task automatic test_store_half;
    issue(1'b1, 3'b001, 32'h202, 32'h0000_ABCD);
    vectors++; if (lsu_bus.bus_we !== 1'b1) begin miscompares++; $display("FAIL sh_bus_we got %b exp 1", lsu_bus.bus_we); end
    vectors++; if (lsu_bus.bus_be !== 4'b1100) begin miscompares++; $display("FAIL sh_bus_be got %b exp 1100", lsu_bus.bus_be); end
    vectors++; if (lsu_bus.bus_wdata !== 32'hABCD_0000) begin miscompares++; $display("FAIL sh_bus_wdata got %h exp abcd0000", lsu_bus.bus_wdata); end
    vectors++; if (lsu_bus.bus_addr !== 32'h200) begin miscompares++; $display("FAIL sh_bus_addr got %h exp 00000200", lsu_bus.bus_addr); end
    ack(32'h5555_5555);
    vectors++; if (lsu_bus.rsp_valid !== 1'b1 || lsu_bus.err !== 1'b0) begin miscompares++; $display("FAIL sh_rsp got rsp=%b err=%b exp rsp=1 err=0", lsu_bus.rsp_valid, lsu_bus.err); end
    vectors++; if (lsu_bus.rdata !== 32'h0) begin miscompares++; $display("FAIL sh_rdata got %h exp 0", lsu_bus.rdata); end
    @(negedge clk);
  endtask

  task automatic test_illegal;
    issue(1'b0, 3'b011, 32'h100, 32'h0);
    vectors++; if (lsu_bus.bus_req !== 1'b0) begin miscompares++; $display("FAIL ill_ld_bus_req got %b exp 0", lsu_bus.bus_req); end
    vectors++; if (lsu_bus.rsp_valid !== 1'b1 || lsu_bus.err !== 1'b1) begin miscompares++; $display("FAIL ill_ld_rsp got rsp=%b err=%b exp 1 1", lsu_bus.rsp_valid, lsu_bus.err); end
    vectors++; if (lsu_bus.rdata !== 32'h0) begin miscompares++; $display("FAIL ill_ld_rdata got %h exp 0", lsu_bus.rdata); end
    @(negedge clk);
    vectors++; if (lsu_bus.rsp_valid !== 1'b0 || lsu_bus.err !== 1'b0) begin miscompares++; $display("FAIL ill_pulse got rsp=%b err=%b exp 0 0", lsu_bus.rsp_valid, lsu_bus.err); end
    issue(1'b1, 3'b100, 32'h100, 32'h12);
    vectors++; if (lsu_bus.rsp_valid !== 1'b1 || lsu_bus.err !== 1'b1 || lsu_bus.bus_req !== 1'b0) begin miscompares++; $display("FAIL ill_st got rsp=%b err=%b req=%b exp 1 1 0", lsu_bus.rsp_valid, lsu_bus.err, lsu_bus.bus_req); end
    @(negedge clk);
  endtask

`ifdef DMEM_LSU_MISALIGN_SPLIT_EN
  task automatic test_split;
    issue(1'b0, 3'b010, 32'h103, 32'h0);
    vectors++; if (lsu_bus.bus_addr !== 32'h100 || lsu_bus.bus_be !== 4'b1000) begin miscompares++; $display("FAIL split_b1 got addr=%h be=%b exp 00000100 1000", lsu_bus.bus_addr, lsu_bus.bus_be); end
    ack(32'h1122_3344);
    vectors++; if (lsu_bus.bus_req !== 1'b1 || lsu_bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL split_b2_req got req=%b rsp=%b exp 1 0", lsu_bus.bus_req, lsu_bus.rsp_valid); end
    vectors++; if (lsu_bus.bus_addr !== 32'h104 || lsu_bus.bus_be !== 4'b0111) begin miscompares++; $display("FAIL split_b2 got addr=%h be=%b exp 00000104 0111", lsu_bus.bus_addr, lsu_bus.bus_be); end
    ack(32'h5566_7788);
    vectors++; if (lsu_bus.rsp_valid !== 1'b1 || lsu_bus.err !== 1'b0) begin miscompares++; $display("FAIL split_rsp got rsp=%b err=%b exp 1 0", lsu_bus.rsp_valid, lsu_bus.err); end
    vectors++; if (lsu_bus.rdata !== 32'h6677_8811) begin miscompares++; $display("FAIL split_rdata got %h exp 66778811", lsu_bus.rdata); end
    @(negedge clk);
  endtask
`else
  task automatic test_misalign;
    issue(1'b0, 3'b010, 32'h101, 32'h0);
    vectors++; if (lsu_bus.bus_req !== 1'b0) begin miscompares++; $display("FAIL mis_lw_bus_req got %b exp 0", lsu_bus.bus_req); end
    vectors++; if (lsu_bus.rsp_valid !== 1'b1 || lsu_bus.err !== 1'b1) begin miscompares++; $display("FAIL mis_lw_rsp got rsp=%b err=%b exp 1 1", lsu_bus.rsp_valid, lsu_bus.err); end
    @(negedge clk);
    issue(1'b1, 3'b001, 32'h203, 32'h1);
    vectors++; if (lsu_bus.rsp_valid !== 1'b1 || lsu_bus.err !== 1'b1 || lsu_bus.bus_req !== 1'b0) begin miscompares++; $display("FAIL mis_sh got rsp=%b err=%b req=%b exp 1 1 0", lsu_bus.rsp_valid, lsu_bus.err, lsu_bus.bus_req); end
    @(negedge clk);
  endtask
`endif

  task automatic test_reset_mid;
    int rsp_seen;
    issue(1'b0, 3'b010, 32'h300, 32'h0);
    vectors++; if (lsu_bus.bus_req !== 1'b1) begin miscompares++; $display("FAIL rm_bus_req_pre got %b exp 1", lsu_bus.bus_req); end
    #2 rst = 1'b1;
    #1;
    vectors++; if (lsu_bus.bus_req !== 1'b0) begin miscompares++; $display("FAIL rm_bus_req got %b exp 0", lsu_bus.bus_req); end
    vectors++; if (lsu_bus.req_ready !== 1'b1) begin miscompares++; $display("FAIL rm_req_ready got %b exp 1", lsu_bus.req_ready); end
    @(negedge clk);
    rst = 1'b0;
    ack(32'hCAFE_F00D);
    rsp_seen = 0;
    for (int i = 0; i < 3; i++) begin
      if (lsu_bus.rsp_valid !== 1'b0) rsp_seen++;
      @(negedge clk);
    end
    vectors++; if (rsp_seen != 0) begin miscompares++; $display("FAIL rm_no_rsp got %0d pulses exp 0", rsp_seen); end
  endtask

  initial begin
    vectors           = 0;
    miscompares       = 0;
    rst               = 1'b1;
    lsu_bus.req_valid = 1'b0;
    lsu_bus.DMWr      = 1'b0;
    lsu_bus.DMCtrl    = 3'b000;
    lsu_bus.addr      = 32'h0;
    lsu_bus.wdata     = 32'h0;
    lsu_bus.bus_ack   = 1'b0;
    lsu_bus.bus_rdata = 32'h0;
    test_reset();
    test_load_word();
    test_load_byte();
    test_store_half();
    test_illegal();
`ifdef DMEM_LSU_MISALIGN_SPLIT_EN
    test_split();
`else
    test_misalign();
`endif
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Load/store unit on the far side of the decoder's data-memory control outputs.
- Takes one memory request per handshake, using the decoder's DMWr/DMCtrl (Funct3 encoding) plus address and store data.
- Runs a word-wide req/ack bus transaction, then returns sign/zero-extended load data with a one-cycle response pulse.
- Sits between the execute stage (ALU result as address) and data memory.

Parameters:
- ADDR_W, 32, address width; bus_addr is always word-aligned.
- RST_RDATA, 32'h0000_0000, rdata value at reset and on error responses.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle and able to accept a request.
- DMWr  in  1  1 = store, 0 = load.
- DMCtrl  in  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr  in  ADDR_W  byte address.
- wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  one-cycle response pulse.
- rdata  out  32  extended load data; 0 for stores.
- err  out  1  valid with rsp_valid; illegal DMCtrl or unsupported misalignment.
- bus_req  out  1  bus request, held until bus_ack.
- bus_we  out  1  bus write.
- bus_addr  out  ADDR_W  word address, {addr[ADDR_W-1:2], 2'b00}.
- bus_be  out  4  byte-lane enables.
- bus_wdata  out  32  lane-shifted store data.
- bus_ack  in  1  one-cycle completion from memory.
- bus_rdata  in  32  read data, valid when bus_ack=1.

Behaviour:
- Reset (async, rst=1): state IDLE; req_ready=1; rsp_valid=0, err=0, bus_req=0, bus_we=0, bus_be=0; bus_addr=0, bus_wdata=0; rdata=RST_RDATA.
- Reset mid-transaction: bus_req drops immediately and the pending response is discarded.
- FSM states: IDLE, BEAT1, BEAT2, RESP.
- IDLE: req_ready=1. When req_valid=1 at an edge, the unit registers DMWr, DMCtrl, addr and wdata.
  - Legal request: go to BEAT1.
  - Illegal request: go to RESP with err=1.
- Illegal DMCtrl: loads 011/110/111; stores any value other than 000/001/010.
- Misalignment: H/HU with addr[0]=1, or W with addr[1:0]!=00, is an error when the macro is absent.
- BEAT1/BEAT2: bus_req=1 and bus signals stay stable until bus_ack=1.
  - On ack, load data is captured.
  - Next state is BEAT2 if a split is pending, otherwise RESP.
  - bus_ack while bus_req=0 is ignored.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. req_ready=0 in every state except IDLE; requests arriving then are ignored.
- Latency: request accepted at edge N; bus_req high from N+1; ack seen at edge M; rsp_valid high in cycle M+1.
- Error latency: rsp_valid in cycle N+1 with no bus activity.
- Lane rules, with off=addr[1:0] and size mask m = 0001/0011/1111:
  - bus_be = m<<off.
  - bus_wdata = wdata<<(8*off).
  - Loads use bus_we=0; byte enables are still driven.
- Load extension: shift the captured data right by 8*off, then:
  - B: sign-extend bit 7.
  - H: sign-extend bit 15.
  - BU/HU: zero-extend.
  - W: pass through.
- Address arithmetic wraps modulo 2^ADDR_W.

Optional Feature:
- Macro: DMEM_LSU_MISALIGN_SPLIT_EN.
- Defined: misaligned accesses are legal.
  - An access that fits inside one word takes one beat, e.g. H at off=01 gives be=0110.
  - An access that crosses a word boundary (H at off=11, W at off!=00) takes two beats.
  - BEAT1 goes to word addr with be=(m<<off)[3:0] and the low half of {32'b0,wdata}<<(8*off).
  - BEAT2 goes to word addr+4 with be=(m<<off)[7:4] and the high half of that shift.
  - Load result is ({beat2,beat1}>>(8*off)), then extended.
- Undefined: any misalignment gives an err response and BEAT2 is unreachable.

Test Plan:
- Load LW, addr=0x100, bus_rdata=0xDEADBEEF, ack after 3 cycles -> bus_addr=0x100, be=1111, we=0; rsp_valid 1 cycle after ack; rdata=0xDEADBEEF, err=0.
- Load LB, addr=0x103, bus_rdata=0x80123456 -> be=1000; rdata=0xFFFFFF80. Same access with LBU -> rdata=0x00000080.
- Store SH, addr=0x202, wdata=0x0000ABCD -> bus_we=1, be=1100, bus_wdata=0xABCD0000; rsp_valid with rdata=0, err=0.
- Without macro: LW at addr=0x101 -> no bus_req; rsp_valid next cycle with err=1. DMCtrl=011 load -> same result.
- With macro: LW at addr=0x103; beat1 rdata=0x11223344 (be=1000); beat2 at 0x104 rdata=0x55667788 (be=0111) -> rdata=0x66778811.
- Assert rst while bus_req=1 in BEAT1 -> bus_req=0 with no clock edge needed; req_ready=1; no rsp_valid afterwards even if ack arrives.
